// File: rtl/dmem_responder.sv
// Data-memory responder: serves 128-bit wld/wst requests as four 32-bit beats
// against a synchronous SRAM, stalling the pipeline for the whole access.
module dmem_responder #(
  parameter int unsigned BEATS  = 4,
  parameter int unsigned RD_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         memEn,
  input  logic         memWrEn,
  input  logic [0:20]  maddr,
  input  logic [0:15]  wbyteen,
  input  logic [0:127] wdata,
  output logic         stall,
  output logic [0:127] rdata,
  output logic         rvalid,
  output logic         m_en,
  output logic         m_we,
  output logic [0:22]  m_addr,
  output logic [0:3]   m_be,
  output logic [0:31]  m_wdata,
  input  logic [0:31]  m_rdata
);

  typedef enum logic [2:0] {IDLE, WR, RD, RDW, DONE} state_t;

  localparam logic [1:0] LAST = 2'(BEATS - 1);

  state_t        state;
  logic [1:0]    k;
  logic          wr_q;
  logic [0:20]   addr_q;
  logic [0:15]   be_q;
  logic [0:127]  wd_q;
  logic [0:95]   stage;
  logic [2:0]    first_beat;
  logic [2:0]    next_wr;
  logic [1:0]    cap_k;

  // Lowest beat index >= from whose enable nibble is nonzero; bit 2 set = none.
  function automatic logic [2:0] next_beat(input logic [0:15] be, input int unsigned from);
    logic [2:0] r;
    r = 3'b100;
    for (int unsigned i = BEATS; i > 0; i--) begin
      if ((i - 1) >= from && be[4*(i-1) +: 4] != 4'b0000)
        r = {1'b0, 2'(i - 1)};
    end
    return r;
  endfunction

  assign first_beat = next_beat(wbyteen, 0);
  assign next_wr    = next_beat(be_q, 32'(k) + 32'd1);
  assign cap_k      = k - 2'(RD_LAT);

  assign stall = (state == IDLE && memEn) || state == WR || state == RD || state == RDW;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      k       <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wd_q    <= '0;
      stage   <= '0;
      rdata   <= '0;
      rvalid  <= 1'b0;
      m_en    <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_be    <= '0;
      m_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          rvalid <= 1'b0;
          if (memEn) begin
            wr_q   <= memWrEn;
            addr_q <= maddr;
            be_q   <= wbyteen;
            wd_q   <= wdata;
            if (memWrEn) begin
              if (first_beat[2]) begin
                state <= DONE;
              end else begin
                state   <= WR;
                k       <= first_beat[1:0];
                m_en    <= 1'b1;
                m_we    <= 1'b1;
                m_addr  <= {maddr, first_beat[1:0]};
                m_be    <= wbyteen[4*first_beat[1:0] +: 4];
                m_wdata <= wdata[32*first_beat[1:0] +: 32];
              end
            end else begin
              state   <= RD;
              k       <= '0;
              m_en    <= 1'b1;
              m_we    <= 1'b0;
              m_addr  <= {maddr, 2'b00};
              m_be    <= '1;
              m_wdata <= '0;
            end
          end
        end
        WR: begin
          if (next_wr[2]) begin
            state   <= DONE;
            m_en    <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_be    <= '0;
            m_wdata <= '0;
          end else begin
            k       <= next_wr[1:0];
            m_addr  <= {addr_q, next_wr[1:0]};
            m_be    <= be_q[4*next_wr[1:0] +: 4];
            m_wdata <= wd_q[32*next_wr[1:0] +: 32];
          end
        end
        RD: begin
          // m_rdata in this cycle answers the read issued RD_LAT beats earlier.
          if (k >= 2'(RD_LAT))
            stage[32*cap_k +: 32] <= m_rdata;
          if (k == LAST) begin
            state  <= RDW;
            m_en   <= 1'b0;
            m_addr <= '0;
            m_be   <= '0;
          end else begin
            k      <= k + 2'd1;
            m_addr <= {addr_q, k + 2'd1};
          end
        end
        RDW: begin
          if (!wr_q) begin
            rdata  <= {stage, m_rdata};
            rvalid <= 1'b1;
          end
          state <= DONE;
        end
        DONE: begin
          rvalid <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: fixed request table, back-to-back and reset corner
// sequences, and randomized requests checked against a request-level memory model.
module tb_dmem_responder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         memEn;
  logic         memWrEn;
  logic [0:20]  maddr;
  logic [0:15]  wbyteen;
  logic [0:127] wdata;
  logic         stall;
  logic [0:127] rdata;
  logic         rvalid;
  logic         m_en;
  logic         m_we;
  logic [0:22]  m_addr;
  logic [0:3]   m_be;
  logic [0:31]  m_wdata;
  logic [0:31]  m_rdata = '0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(.BEATS(4), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .memEn(memEn), .memWrEn(memWrEn), .maddr(maddr),
    .wbyteen(wbyteen), .wdata(wdata), .stall(stall), .rdata(rdata), .rvalid(rvalid),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_be(m_be), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  // Unwritten SRAM words read back as 0xA0000000 + word address.
  function automatic logic [0:31] dflt(input int unsigned a);
    return 32'hA000_0000 + a;
  endfunction

  // SRAM environment: byte-masked writes, one-cycle read latency, noise otherwise.
  logic [0:31]  sram [int unsigned];
  int unsigned  sa;
  logic [0:31]  sw;
  always @(posedge clk) begin
    sa = 32'(m_addr);
    if (m_en && m_we) begin
      sw = sram.exists(sa) ? sram[sa] : dflt(sa);
      for (int b = 0; b < 4; b++)
        if (m_be[b]) sw[8*b +: 8] = m_wdata[8*b +: 8];
      sram[sa] = sw;
    end
    if (m_en && !m_we) m_rdata <= sram.exists(sa) ? sram[sa] : dflt(sa);
    else               m_rdata <= $urandom;
  end

  // Reference model: expected memory contents and last load result.
  logic [0:31]  rmem [int unsigned];
  logic [0:127] last_rdata = '0;

  function automatic int unsigned waddr(input logic [0:20] a, input int k);
    return (32'(a) << 2) | 32'(k & 3);
  endfunction

  function automatic logic [0:31] ref_word(input int unsigned a);
    return rmem.exists(a) ? rmem[a] : dflt(a);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, " stall"}, stall, 0);
    chk({tag, " rvalid"}, rvalid, 0);
    chk({tag, " rdata"}, rdata, 0);
    chk({tag, " m_en"}, m_en, 0);
    chk({tag, " m_we"}, m_we, 0);
    chk({tag, " m_be"}, m_be, 0);
    chk({tag, " m_addr"}, m_addr, 0);
    chk({tag, " m_wdata"}, m_wdata, 0);
  endtask

  // One request from its T0 through its DONE cycle; returns after the DONE edge.
  task automatic do_req(input logic we, input logic [0:20] a, input logic [0:15] be,
                        input logic [0:127] d, input int drop_at, input bit scramble,
                        output int nbeats, output logic [0:127] ld);
    int           beats[$];
    int           done_c;
    int           nb_exp;
    logic [0:127] exp_ld;
    bit           issue;
    string        tg;
    nbeats = 0;
    exp_ld = last_rdata;
    if (we) begin
      for (int k = 0; k < 4; k++)
        if (be[4*k +: 4] != 4'b0000) beats.push_back(k);
      for (int i = 0; i < 16; i++) begin
        if (be[i]) begin
          int unsigned wa;
          logic [0:31] w;
          wa = waddr(a, i / 4);
          w = ref_word(wa);
          w[8*(i%4) +: 8] = d[8*i +: 8];
          rmem[wa] = w;
        end
      end
      nb_exp = beats.size();
      done_c = nb_exp + 1;
    end else begin
      for (int k = 0; k < 4; k++) begin
        beats.push_back(k);
        exp_ld[32*k +: 32] = ref_word(waddr(a, k));
      end
      nb_exp = 4;
      done_c = 6;
    end
    memEn = 1'b1; memWrEn = we; maddr = a; wbyteen = be; wdata = d;
    for (int c = 0; c <= done_c; c++) begin
      if (c == drop_at) memEn = 1'b0;
      if (scramble && c >= 1) begin
        memWrEn = 1'($urandom); maddr = 21'($urandom); wbyteen = 16'($urandom);
        wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      tg = $sformatf("%s@%h T%0d", we ? "st" : "ld", a, c);
      issue = (c >= 1 && c <= nb_exp);
      chk({tg, " stall"}, stall, c < done_c);
      chk({tg, " m_en"}, m_en, issue);
      if (m_en) nbeats++;
      if (issue) begin
        chk({tg, " m_we"}, m_we, we);
        chk({tg, " m_addr"}, m_addr, {a, 2'(beats[c-1])});
        chk({tg, " m_be"}, m_be, we ? be[4*beats[c-1] +: 4] : 4'hF);
        if (we) chk({tg, " m_wdata"}, m_wdata, d[32*beats[c-1] +: 32]);
      end else begin
        chk({tg, " m_we"}, m_we, 0);
        chk({tg, " m_addr"}, m_addr, 0);
        chk({tg, " m_be"}, m_be, 0);
        chk({tg, " m_wdata"}, m_wdata, 0);
      end
      if (!we && c == done_c) last_rdata = exp_ld;
      chk({tg, " rvalid"}, rvalid, !we && c == done_c);
      chk({tg, " rdata"}, rdata, last_rdata);
      if (c == done_c) ld = rdata;
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic         we;
    logic [0:20]  a;
    logic [0:15]  be;
    logic [0:127] d;
    int           exp_beats;
    logic [0:127] exp_rd;
  } vec_t;

  vec_t         tbl [10];
  int           nb;
  logic [0:127] ld;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; memEn = 1'b0; memWrEn = 1'b0; maddr = '0; wbyteen = '0; wdata = '0;

    tbl[0] = '{1'b1, 21'h5, 16'hFFFF, 128'h00112233_44556677_8899AABB_CCDDEEFF, 4, 128'h0};
    tbl[1] = '{1'b1, 21'h6, 16'h00F0, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 1, 128'h0};
    tbl[2] = '{1'b1, 21'h7, 16'h0000, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 0, 128'h0};
    tbl[3] = '{1'b0, 21'h0, 16'h0000, 128'h0, 4, 128'hA0000000_A0000001_A0000002_A0000003};
    tbl[4] = '{1'b1, 21'h8, 16'h0F0F, 128'h11111111_22222222_33333333_44444444, 2,
               128'hA0000000_A0000001_A0000002_A0000003};
    tbl[5] = '{1'b0, 21'h5, 16'h0000, 128'h0, 4, 128'h00112233_44556677_8899AABB_CCDDEEFF};
    tbl[6] = '{1'b0, 21'h6, 16'h0000, 128'h0, 4, 128'hA0000018_A0000019_01234567_A000001B};
    tbl[7] = '{1'b0, 21'h8, 16'h0000, 128'h0, 4, 128'hA0000020_22222222_A0000022_44444444};
    tbl[8] = '{1'b1, 21'h9, 16'h8001, 128'h5A000000_00000000_00000000_000000A5, 2,
               128'hA0000020_22222222_A0000022_44444444};
    tbl[9] = '{1'b0, 21'h9, 16'h0000, 128'h0, 4, 128'h5A000024_A0000025_A0000026_A00000A5};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle_outs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post-reset stall", stall, 0);
    chk("post-reset m_en", m_en, 0);
    @(posedge clk); #1;

    // Directed table, issued back to back
    for (int i = 0; i < 10; i++) begin
      do_req(tbl[i].we, tbl[i].a, tbl[i].be, tbl[i].d, -1, 1'b0, nb, ld);
      chk($sformatf("tbl%0d beats", i), nb, tbl[i].exp_beats);
      chk($sformatf("tbl%0d rdata", i), ld, tbl[i].exp_rd);
    end

    // Load with memEn dropped in T2, then a store whose T0 is T7 of the load
    do_req(1'b0, 21'h0, 16'h0, 128'h0, 2, 1'b0, nb, ld);
    chk("drop load rdata", ld, 128'hA0000000_A0000001_A0000002_A0000003);
    do_req(1'b1, 21'h10, 16'hFFFF, 128'h0F0E0D0C_0B0A0908_07060504_03020100, -1, 1'b0, nb, ld);
    chk("b2b store beats", nb, 4);
    chk("b2b store rdata held", ld, 128'hA0000000_A0000001_A0000002_A0000003);

    // Randomized requests, inputs scrambled after latching
    for (int i = 0; i < 40; i++) begin
      logic         we;
      logic [0:15]  be;
      logic [0:127] d;
      int           sel;
      we  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 3);
      be  = (sel == 0) ? 16'h0000 : (sel == 1) ? 16'hFFFF : 16'($urandom);
      d   = {$urandom, $urandom, $urandom, $urandom};
      do_req(we, 21'h40 + 21'($urandom_range(0, 3)), be, d, $urandom_range(1, 4), 1'b1, nb, ld);
    end
    memEn = 1'b0;

    // Asynchronous reset in the middle of a store, mid high phase of the clock
    memEn = 1'b1; memWrEn = 1'b1; maddr = 21'h1F000; wbyteen = 16'hFFFF;
    wdata = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    @(posedge clk); #2;
    chk("pre-abort m_en", m_en, 1);
    rst_n = 1'b0; memEn = 1'b0;
    #1;
    chk_idle_outs("async-reset");
    last_rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("release stall", stall, 0);
    chk("release m_en", m_en, 0);
    @(posedge clk); #1;

    // Reset during T3 of a load: no completion, rdata cleared
    do_req(1'b0, 21'h5, 16'h0, 128'h0, -1, 1'b0, nb, ld);
    chk("pre-abort load rdata", ld, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    memEn = 1'b1; memWrEn = 1'b0; maddr = 21'h0;
    repeat (3) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0; memEn = 1'b0;
    #1;
    chk_idle_outs("load-abort");
    last_rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("after-abort c%0d rvalid", c), rvalid, 0);
      chk($sformatf("after-abort c%0d rdata", c), rdata, 0);
      chk($sformatf("after-abort c%0d m_en", c), m_en, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
